id_ex_issue: RTL and testbench

Decode-and-issue stage of the five-stage MIPS pipeline. It is the producer side of the EX-stage ALU interface. It decodes the ID-stage instruction into a 3-bit ALU opcode, selects operand B (register value or zero/sign-extended immediate), picks the destination register, and registers everything into the ID/EX pipeline register. The register supports hold (stall), bubble insertion (flush) and a valid bit.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/issue_decode.sv | 83 ++++++++
 rtl/id_ex_issue.sv | 113 +++++++++++
 tb/tb_id_ex_issue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the ID/EX issue stage.
package mips_pkg;

   // ALU opcodes understood by the EX stage.
   typedef enum logic [2:0] {
      AluAddu = 3'b000,
      AluSubu = 3'b001,
      AluAnd  = 3'b010,
      AluOr   = 3'b011,
      AluLui  = 3'b100
   } alu_op_e;

   // Which instruction field names the destination register.
   typedef enum logic [1:0] {
      WregNone = 2'd0,
      WregRd   = 2'd1,
      WregRt   = 2'd2
   } wreg_sel_e;

   // Primary opcodes, instr[31:26].
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes, instr[5:0].
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;

   // Contents of the ID/EX pipeline register.
   typedef struct packed {
      logic        valid;
      alu_op_e     aluop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] store_data;
      logic [4:0]  wreg;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic [31:0] pc;
      logic        illegal;
   } id_ex_t;

   // An empty slot: nothing valid, no side effects.
   function automatic id_ex_t bubble(input logic [31:0] pc);
      id_ex_t b;
      b            = '0;
      b.aluop      = AluAddu;
      b.pc         = pc;
      return b;
   endfunction

endpackage

// File: rtl/issue_decode.sv
// Combinational instruction decoder for the issue stage.
module issue_decode
   import mips_pkg::*;
(
   input  logic [31:0] instr,
   output alu_op_e     aluop,
   output logic        bsel,      // 1: immediate, 0: rt value
   output logic        ext_sign,  // 1: sign-extend imm16
   output wreg_sel_e   wreg_sel,
   output logic        memread,
   output logic        memwrite,
   output logic        nop,
   output logic        illegal
);

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = instr[31:26];
   assign funct = instr[5:0];

   // Decode opcode/funct into control fields.
   always_comb begin
      aluop    = AluAddu;
      bsel     = 1'b0;
      ext_sign = 1'b0;
      wreg_sel = WregNone;
      memread  = 1'b0;
      memwrite = 1'b0;
      nop      = 1'b0;
      illegal  = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            if (instr == 32'h0) begin
               nop = 1'b1;
            end else begin
               wreg_sel = WregRd;
               unique case (funct)
                  FN_ADDU: aluop = AluAddu;
                  FN_SUBU: aluop = AluSubu;
                  FN_AND:  aluop = AluAnd;
                  FN_OR:   aluop = AluOr;
                  default: begin
                     wreg_sel = WregNone;
                     illegal  = 1'b1;
                  end
               endcase
            end
         end
         OP_ORI: begin
            aluop    = AluOr;
            bsel     = 1'b1;
            wreg_sel = WregRt;
         end
         OP_ANDI: begin
            aluop    = AluAnd;
            bsel     = 1'b1;
            wreg_sel = WregRt;
         end
         OP_LUI: begin
            aluop    = AluLui;
            bsel     = 1'b1;
            wreg_sel = WregRt;
         end
         OP_LW: begin
            bsel     = 1'b1;
            ext_sign = 1'b1;
            wreg_sel = WregRt;
            memread  = 1'b1;
         end
         OP_SW: begin
            bsel     = 1'b1;
            ext_sign = 1'b1;
            memwrite = 1'b1;
         end
         OP_BEQ: begin
            aluop = AluAddu;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_issue.sv
// Decode-and-issue stage: decodes the ID instruction and registers it into ID/EX.
module id_ex_issue
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs_val,
   input  logic [31:0] id_rt_val,
   input  logic        ex_stall,
   input  logic        ex_flush,
   output logic        ex_valid,
   output logic [2:0]  ex_aluop,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_wreg,
   output logic        ex_regwrite,
   output logic        ex_memread,
   output logic        ex_memwrite,
   output logic [31:0] ex_pc,
   output logic        ex_illegal
);

   alu_op_e   dec_aluop;
   logic      dec_bsel;
   logic      dec_ext_sign;
   wreg_sel_e dec_wreg_sel;
   logic      dec_memread;
   logic      dec_memwrite;
   logic      dec_nop;
   logic      dec_illegal;

   id_ex_t    id_bundle;
   id_ex_t    ex_q;
   logic [31:0] imm_ext;
   logic [4:0]  wreg;

   issue_decode u_decode (
      .instr    (id_instr),
      .aluop    (dec_aluop),
      .bsel     (dec_bsel),
      .ext_sign (dec_ext_sign),
      .wreg_sel (dec_wreg_sel),
      .memread  (dec_memread),
      .memwrite (dec_memwrite),
      .nop      (dec_nop),
      .illegal  (dec_illegal)
   );

   assign imm_ext = dec_ext_sign ? {{16{id_instr[15]}}, id_instr[15:0]}
                                 : {16'h0000, id_instr[15:0]};

   // Destination register mux.
   always_comb begin
      wreg = 5'd0;
      unique case (dec_wreg_sel)
         WregRd:  wreg = id_instr[15:11];
         WregRt:  wreg = id_instr[20:16];
         default: wreg = 5'd0;
      endcase
   end

   // Assemble the next ID/EX contents; nop and illegal become valid bubbles.
   always_comb begin
      id_bundle = bubble(PC_RESET);
      if (id_valid) begin
         if (dec_nop || dec_illegal) begin
            id_bundle.valid   = 1'b1;
            id_bundle.illegal = dec_illegal;
         end else begin
            id_bundle.valid      = 1'b1;
            id_bundle.aluop      = dec_aluop;
            id_bundle.a          = id_rs_val;
            id_bundle.b          = dec_bsel ? imm_ext : id_rt_val;
            id_bundle.store_data = dec_memwrite ? id_rt_val : 32'h0;
            id_bundle.wreg       = wreg;
            id_bundle.regwrite   = (wreg != 5'd0);
            id_bundle.memread    = dec_memread;
            id_bundle.memwrite   = dec_memwrite;
            id_bundle.pc         = id_pc;
         end
      end
   end

   // ID/EX register: flush beats stall, stall holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= bubble(PC_RESET);
      end else if (ex_flush) begin
         ex_q <= bubble(PC_RESET);
      end else if (!ex_stall) begin
         ex_q <= id_bundle;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_aluop      = ex_q.aluop;
   assign ex_a          = ex_q.a;
   assign ex_b          = ex_q.b;
   assign ex_store_data = ex_q.store_data;
   assign ex_wreg       = ex_q.wreg;
   assign ex_regwrite   = ex_q.regwrite;
   assign ex_memread    = ex_q.memread;
   assign ex_memwrite   = ex_q.memwrite;
   assign ex_pc         = ex_q.pc;
   assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed self-checking bench for id_ex_issue.
module tb_id_ex_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_rs_val;
   logic [31:0] id_rt_val;
   logic        ex_stall;
   logic        ex_flush;
   logic        ex_valid;
   logic [2:0]  ex_aluop;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_wreg;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic [31:0] ex_pc;
   logic        ex_illegal;

   int checks = 0;
   int errors = 0;

   id_ex_issue dut (
      .clk           (clk),
      .reset         (reset),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .id_rs_val     (id_rs_val),
      .id_rt_val     (id_rt_val),
      .ex_stall      (ex_stall),
      .ex_flush      (ex_flush),
      .ex_valid      (ex_valid),
      .ex_aluop      (ex_aluop),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_store_data (ex_store_data),
      .ex_wreg       (ex_wreg),
      .ex_regwrite   (ex_regwrite),
      .ex_memread    (ex_memread),
      .ex_memwrite   (ex_memwrite),
      .ex_pc         (ex_pc),
      .ex_illegal    (ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt);
      id_valid  = v;
      id_instr  = instr;
      id_pc     = pc;
      id_rs_val = rs;
      id_rt_val = rt;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd0);
      chk({tag, ".aluop"}, {29'b0, ex_aluop}, 32'd0);
      chk({tag, ".a"}, ex_a, 32'd0);
      chk({tag, ".b"}, ex_b, 32'd0);
      chk({tag, ".sd"}, ex_store_data, 32'd0);
      chk({tag, ".wreg"}, {27'b0, ex_wreg}, 32'd0);
      chk({tag, ".ctl"}, {28'b0, ex_regwrite, ex_memread, ex_memwrite, ex_illegal}, 32'd0);
      chk({tag, ".pc"}, ex_pc, 32'h0000_3000);
   endtask

   initial begin
      reset    = 1'b1;
      ex_stall = 1'b0;
      ex_flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      #3;
      chk_bubble("reset_held");
      step();
      step();
      reset = 1'b0;
      step();
      chk_bubble("after_reset");

      // addu $3,$1,$2
      drive(1'b1, 32'h0022_1821, 32'h0000_3004, 32'd5, 32'd7);
      step();
      chk("addu.valid", {31'b0, ex_valid}, 32'd1);
      chk("addu.aluop", {29'b0, ex_aluop}, 32'd0);
      chk("addu.a", ex_a, 32'd5);
      chk("addu.b", ex_b, 32'd7);
      chk("addu.wreg", {27'b0, ex_wreg}, 32'd3);
      chk("addu.regwrite", {31'b0, ex_regwrite}, 32'd1);
      chk("addu.pc", ex_pc, 32'h0000_3004);

      // ori $4,$1,0xFFFF
      drive(1'b1, 32'h3424_FFFF, 32'h0000_3008, 32'd1, 32'd2);
      step();
      chk("ori.aluop", {29'b0, ex_aluop}, 32'd3);
      chk("ori.b", ex_b, 32'h0000_FFFF);
      chk("ori.wreg", {27'b0, ex_wreg}, 32'd4);

      // lui $5,0x1234
      drive(1'b1, 32'h3C05_1234, 32'h0000_300C, 32'd1, 32'd2);
      step();
      chk("lui.aluop", {29'b0, ex_aluop}, 32'd4);
      chk("lui.b", ex_b, 32'h0000_1234);
      chk("lui.wreg", {27'b0, ex_wreg}, 32'd5);

      // subu $7,$1,$2
      drive(1'b1, 32'h0022_3823, 32'h0000_3010, 32'd9, 32'd4);
      step();
      chk("subu.aluop", {29'b0, ex_aluop}, 32'd1);
      chk("subu.wreg", {27'b0, ex_wreg}, 32'd7);

      // lw $6,-4($1)
      drive(1'b1, 32'h8C26_FFFC, 32'h0000_3014, 32'h100, 32'd2);
      step();
      chk("lw.aluop", {29'b0, ex_aluop}, 32'd0);
      chk("lw.a", ex_a, 32'h100);
      chk("lw.b", ex_b, 32'hFFFF_FFFC);
      chk("lw.memread", {31'b0, ex_memread}, 32'd1);
      chk("lw.wreg", {27'b0, ex_wreg}, 32'd6);

      // sw $2,8($1)
      drive(1'b1, 32'hAC22_0008, 32'h0000_3018, 32'h200, 32'd9);
      step();
      chk("sw.memwrite", {31'b0, ex_memwrite}, 32'd1);
      chk("sw.store_data", ex_store_data, 32'd9);
      chk("sw.regwrite", {31'b0, ex_regwrite}, 32'd0);
      chk("sw.b", ex_b, 32'd8);
      chk("sw.wreg", {27'b0, ex_wreg}, 32'd0);

      // Stall holds addu while ID changes to sw.
      drive(1'b1, 32'h0022_1821, 32'h0000_301C, 32'd5, 32'd7);
      step();
      ex_stall = 1'b1;
      drive(1'b1, 32'hAC22_0008, 32'h0000_3020, 32'h200, 32'd9);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall.b", ex_b, 32'd7);
         chk("stall.wreg", {27'b0, ex_wreg}, 32'd3);
         chk("stall.memwrite", {31'b0, ex_memwrite}, 32'd0);
         chk("stall.pc", ex_pc, 32'h0000_301C);
      end
      ex_flush = 1'b1;
      step();
      chk_bubble("stall_flush");
      ex_stall = 1'b0;
      ex_flush = 1'b0;

      // Unsupported encoding.
      drive(1'b1, 32'hFC00_0000, 32'h0000_3024, 32'd1, 32'd2);
      step();
      chk("ill.valid", {31'b0, ex_valid}, 32'd1);
      chk("ill.illegal", {31'b0, ex_illegal}, 32'd1);
      chk("ill.ctl", {29'b0, ex_regwrite, ex_memread, ex_memwrite}, 32'd0);

      // addu $0,$1,$2: write to $0 squashed.
      drive(1'b1, 32'h0022_0021, 32'h0000_3028, 32'd1, 32'd2);
      step();
      chk("zero.wreg", {27'b0, ex_wreg}, 32'd0);
      chk("zero.regwrite", {31'b0, ex_regwrite}, 32'd0);
      chk("zero.valid", {31'b0, ex_valid}, 32'd1);

      // nop.
      drive(1'b1, 32'h0000_0000, 32'h0000_302C, 32'd1, 32'd2);
      step();
      chk("nop.valid", {31'b0, ex_valid}, 32'd1);
      chk("nop.illegal", {31'b0, ex_illegal}, 32'd0);
      chk("nop.regwrite", {31'b0, ex_regwrite}, 32'd0);

      // id_valid low loads a bubble.
      drive(1'b0, 32'h0022_1821, 32'h0000_3030, 32'd5, 32'd7);
      step();
      chk_bubble("invalid");

      // Async reset while a valid instruction is held.
      drive(1'b1, 32'h0022_1821, 32'h0000_3034, 32'd5, 32'd7);
      step();
      chk("pre_rst.valid", {31'b0, ex_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_bubble("async_reset");
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("post_rst.a", ex_a, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
